fft8: RTL and testbench



---
 rtl/fft_pkg.sv | 10 +
 rtl/fft_bf2.sv | 23 ++
 rtl/fft8.sv | 184 ++++++++++++++++++
 tb/tb_fft8.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the 8-point pipelined FFT.
package fft_pkg;

  localparam int IW     = 8;                 // input sample width (signed)
  localparam int OW     = IW + 3;            // output width, absorbs log2(8) growth
  localparam int TW_C   = 181;               // cos(pi/4) in Q0.8
  localparam int TW_SH  = 8;                 // fractional bits of TW_C
  localparam int TW_RND = 1 << (TW_SH - 1);  // round-half-up offset

endpackage

// File: rtl/fft_bf2.sv
// Complex radix-2 butterfly: s = a + b, d = a - b, all at DATA_W bits.
// Callers sign-extend the operands to the stage width beforehand.
module fft_bf2
  import fft_pkg::*;
#(
  parameter int DATA_W = IW + 1
) (
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  output logic signed [DATA_W-1:0] s_re,
  output logic signed [DATA_W-1:0] s_im,
  output logic signed [DATA_W-1:0] d_re,
  output logic signed [DATA_W-1:0] d_im
);

  assign s_re = a_re + b_re;
  assign s_im = a_im + b_im;
  assign d_re = a_re - b_re;
  assign d_im = a_im - b_im;

endmodule

// File: rtl/fft8.sv
// Fully parallel 8-point radix-2 DIT FFT, three register stages, natural-order
// output, no scaling (output is IW+3 bits wide with the input LSB weight).
module fft8
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 en,
  input  logic                 rst,
  input  logic signed [IW-1:0] i_re0, i_re1, i_re2, i_re3,
  input  logic signed [IW-1:0] i_re4, i_re5, i_re6, i_re7,
  input  logic signed [IW-1:0] i_im0, i_im1, i_im2, i_im3,
  input  logic signed [IW-1:0] i_im4, i_im5, i_im6, i_im7,
  output logic signed [OW-1:0] o_re0, o_re1, o_re2, o_re3,
  output logic signed [OW-1:0] o_re4, o_re5, o_re6, o_re7,
  output logic signed [OW-1:0] o_im0, o_im1, o_im2, o_im3,
  output logic signed [OW-1:0] o_im4, o_im5, o_im6, o_im7
);

  localparam int W1 = IW + 1;
  localparam int W2 = IW + 2;
  localparam int PW = W2 + 10;
  localparam logic signed [PW-1:0] TWC_P = PW'(TW_C);
  localparam logic signed [PW-1:0] RND_P = PW'(TW_RND);

  function automatic logic signed [W1-1:0] ext0(input logic signed [IW-1:0] v);
    return {v[IW-1], v};
  endfunction

  function automatic logic signed [W2-1:0] ext1(input logic signed [W1-1:0] v);
    return {v[W1-1], v};
  endfunction

  function automatic logic signed [OW-1:0] ext2(input logic signed [W2-1:0] v);
    return {{(OW-W2){v[W2-1]}}, v};
  endfunction

  // Full-precision product v * TW_C.
  function automatic logic signed [PW-1:0] mul_c(input logic signed [W2-1:0] v);
    return $signed({{(PW-W2){v[W2-1]}}, v}) * TWC_P;
  endfunction

  // (p + 128) >>> 8, kept at the stage-2 width; |result| <= 362 always fits.
  function automatic logic signed [W2-1:0] rnd_sh(input logic signed [PW-1:0] p);
    return W2'((p + RND_P) >>> TW_SH);
  endfunction

  logic signed [W1-1:0] xr [8], xi [8];
  logic signed [W1-1:0] s1_re [8], s1_im [8];
  logic signed [W1-1:0] p0_re [8], p0_im [8];
  logic signed [W2-1:0] q_re [8], q_im [8];
  logic signed [W2-1:0] s2_re [8], s2_im [8];
  logic signed [W2-1:0] p1_re [8], p1_im [8];
  logic signed [OW-1:0] e_re [4], e_im [4], t_re [4], t_im [4];
  logic signed [W2-1:0] c1a, c1b, c3a, c3b;
  logic signed [OW-1:0] s3_re [8], s3_im [8];
  logic signed [OW-1:0] p2_re [8], p2_im [8];

  assign xr[0] = ext0(i_re0); assign xi[0] = ext0(i_im0);
  assign xr[1] = ext0(i_re1); assign xi[1] = ext0(i_im1);
  assign xr[2] = ext0(i_re2); assign xi[2] = ext0(i_im2);
  assign xr[3] = ext0(i_re3); assign xi[3] = ext0(i_im3);
  assign xr[4] = ext0(i_re4); assign xi[4] = ext0(i_im4);
  assign xr[5] = ext0(i_re5); assign xi[5] = ext0(i_im5);
  assign xr[6] = ext0(i_re6); assign xi[6] = ext0(i_im6);
  assign xr[7] = ext0(i_re7); assign xi[7] = ext0(i_im7);

  // Stage 1: bit-reversed pairs (0,4),(2,6),(1,5),(3,7) -> slots {sum, diff}
  for (genvar g = 0; g < 4; g++) begin : g_st1
    localparam int A = ((g % 2) * 2) + (g / 2);
    fft_bf2 #(.DATA_W(W1)) u_bf (
      .a_re(xr[A]), .a_im(xi[A]), .b_re(xr[A+4]), .b_im(xi[A+4]),
      .s_re(s1_re[2*g]), .s_im(s1_im[2*g]),
      .d_re(s1_re[2*g+1]), .d_im(s1_im[2*g+1])
    );
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 8; n++) begin
        p0_re[n] <= '0;
        p0_im[n] <= '0;
      end
    end else if (en) begin
      for (int n = 0; n < 8; n++) begin
        p0_re[n] <= s1_re[n];
        p0_im[n] <= s1_im[n];
      end
    end
  end

  // Stage 2 operands: widen, and rotate slots 3 and 7 by -j (swap/negate)
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      q_re[n] = ext1(p0_re[n]);
      q_im[n] = ext1(p0_im[n]);
    end
    for (int h = 0; h < 2; h++) begin
      q_re[4*h+3] = ext1(p0_im[4*h+3]);
      q_im[4*h+3] = -ext1(p0_re[4*h+3]);
    end
  end

  // Stage 2: two 4-point DFTs, slots 0..3 = E[0..3], slots 4..7 = O[0..3]
  for (genvar h = 0; h < 2; h++) begin : g_st2
    for (genvar r = 0; r < 2; r++) begin : g_bf
      fft_bf2 #(.DATA_W(W2)) u_bf (
        .a_re(q_re[4*h+r]), .a_im(q_im[4*h+r]),
        .b_re(q_re[4*h+r+2]), .b_im(q_im[4*h+r+2]),
        .s_re(s2_re[4*h+r]), .s_im(s2_im[4*h+r]),
        .d_re(s2_re[4*h+r+2]), .d_im(s2_im[4*h+r+2])
      );
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 8; n++) begin
        p1_re[n] <= '0;
        p1_im[n] <= '0;
      end
    end else if (en) begin
      for (int n = 0; n < 8; n++) begin
        p1_re[n] <= s2_re[n];
        p1_im[n] <= s2_im[n];
      end
    end
  end

  // Stage 3 operands: E[k] widened, O[k] rotated by W^k
  always_comb begin
    c1a = rnd_sh(mul_c(p1_re[5]));
    c1b = rnd_sh(mul_c(p1_im[5]));
    c3a = rnd_sh(mul_c(p1_re[7]));
    c3b = rnd_sh(mul_c(p1_im[7]));
    for (int k = 0; k < 4; k++) begin
      e_re[k] = ext2(p1_re[k]);
      e_im[k] = ext2(p1_im[k]);
    end
    t_re[0] = ext2(p1_re[4]);
    t_im[0] = ext2(p1_im[4]);
    t_re[1] = ext2(c1a) + ext2(c1b);
    t_im[1] = ext2(c1b) - ext2(c1a);
    t_re[2] = ext2(p1_im[6]);
    t_im[2] = -ext2(p1_re[6]);
    t_re[3] = ext2(c3b) - ext2(c3a);
    t_im[3] = -ext2(c3a) - ext2(c3b);
  end

  // Stage 3: X[k] = E[k] + W^k O[k], X[k+4] = E[k] - W^k O[k]
  for (genvar k = 0; k < 4; k++) begin : g_st3
    fft_bf2 #(.DATA_W(OW)) u_bf (
      .a_re(e_re[k]), .a_im(e_im[k]), .b_re(t_re[k]), .b_im(t_im[k]),
      .s_re(s3_re[k]), .s_im(s3_im[k]),
      .d_re(s3_re[k+4]), .d_im(s3_im[k+4])
    );
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 8; n++) begin
        p2_re[n] <= '0;
        p2_im[n] <= '0;
      end
    end else if (en) begin
      for (int n = 0; n < 8; n++) begin
        p2_re[n] <= s3_re[n];
        p2_im[n] <= s3_im[n];
      end
    end
  end

  assign o_re0 = p2_re[0]; assign o_im0 = p2_im[0];
  assign o_re1 = p2_re[1]; assign o_im1 = p2_im[1];
  assign o_re2 = p2_re[2]; assign o_im2 = p2_im[2];
  assign o_re3 = p2_re[3]; assign o_im3 = p2_im[3];
  assign o_re4 = p2_re[4]; assign o_im4 = p2_im[4];
  assign o_re5 = p2_re[5]; assign o_im5 = p2_im[5];
  assign o_re6 = p2_re[6]; assign o_im6 = p2_im[6];
  assign o_re7 = p2_re[7]; assign o_im7 = p2_im[7];

endmodule

// File: tb/tb_fft8.sv
// Directed-vector bench for fft8 with hand-computed expected bins.
module tb_fft8;

  logic clk = 1'b0;
  logic en;
  logic rst;
  logic signed [7:0]  xr [8], xi [8];
  logic signed [10:0] yr [8], yi [8];
  int checks = 0;
  int failures = 0;
  int er [8], ei [8];
  int mix_re [8] = '{4, 12, 4, 12, 8, 4, 4, 4};

  always #5 clk = ~clk;

  fft8 dut (
    .clk(clk), .en(en), .rst(rst),
    .i_re0(xr[0]), .i_re1(xr[1]), .i_re2(xr[2]), .i_re3(xr[3]),
    .i_re4(xr[4]), .i_re5(xr[5]), .i_re6(xr[6]), .i_re7(xr[7]),
    .i_im0(xi[0]), .i_im1(xi[1]), .i_im2(xi[2]), .i_im3(xi[3]),
    .i_im4(xi[4]), .i_im5(xi[5]), .i_im6(xi[6]), .i_im7(xi[7]),
    .o_re0(yr[0]), .o_re1(yr[1]), .o_re2(yr[2]), .o_re3(yr[3]),
    .o_re4(yr[4]), .o_re5(yr[5]), .o_re6(yr[6]), .o_re7(yr[7]),
    .o_im0(yi[0]), .o_im1(yi[1]), .o_im2(yi[2]), .o_im3(yi[3]),
    .o_im4(yi[4]), .o_im5(yi[5]), .o_im6(yi[6]), .o_im7(yi[7])
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input int r, input int i);
    for (int n = 0; n < 8; n++) begin
      xr[n] = 8'(r);
      xi[n] = 8'(i);
    end
  endtask

  task automatic expect_only0(input int r0, input int i0);
    for (int k = 0; k < 8; k++) begin
      er[k] = 0;
      ei[k] = 0;
    end
    er[0] = r0;
    ei[0] = i0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    fill(0, 0);
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== 0 || int'(yi[k]) !== 0) begin
        failures++;
        $display("FAIL reset_init X%0d: got re=%0d im=%0d, expected 0", k, yr[k], yi[k]);
      end
    end
    #2 rst = 1'b0;
    en = 1'b1;
    xr[0] = 8'sd32;
    tick(3);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== 32 || int'(yi[k]) !== 0) begin
        failures++;
        $display("FAIL reset_pre X%0d: got re=%0d im=%0d, expected re=32 im=0", k, yr[k], yi[k]);
      end
    end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== 0 || int'(yi[k]) !== 0) begin
        failures++;
        $display("FAIL reset_async X%0d: got re=%0d im=%0d, expected 0", k, yr[k], yi[k]);
      end
    end
    fill(32, 0);
    #1 rst = 1'b0;
    tick(2);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== 0 || int'(yi[k]) !== 0) begin
        failures++;
        $display("FAIL reset_hold X%0d: got re=%0d im=%0d, expected 0", k, yr[k], yi[k]);
      end
    end
    tick(1);
    expect_only0(256, 0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== er[k] || int'(yi[k]) !== ei[k]) begin
        failures++;
        $display("FAIL reset_first X%0d: got re=%0d im=%0d, expected re=%0d im=%0d", k, yr[k], yi[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_impulse();
    fill(0, 0);
    xr[0] = 8'sd32;
    tick(3);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== 32 || int'(yi[k]) !== 0) begin
        failures++;
        $display("FAIL impulse X%0d: got re=%0d im=%0d, expected re=32 im=0", k, yr[k], yi[k]);
      end
    end
  endtask

  task automatic test_dc();
    fill(32, 0);
    tick(3);
    expect_only0(256, 0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== er[k] || int'(yi[k]) !== ei[k]) begin
        failures++;
        $display("FAIL dc X%0d: got re=%0d im=%0d, expected re=%0d im=%0d", k, yr[k], yi[k], er[k], ei[k]);
      end
    end
  endtask

  task automatic test_mixed();
    int exr [8] = '{52, -4, 4, -4, -12, -4, 4, -4};
    int exi [8] = '{0, -11, 0, -11, 0, 11, 0, 11};
    for (int n = 0; n < 8; n++) begin
      xr[n] = 8'(mix_re[n]);
      xi[n] = 8'sd0;
    end
    tick(1);
    fill(0, 0);
    tick(2);
    for (int k = 0; k < 8; k++) begin
      int vr;
      int vi;
      vr = int'(yr[k]);
      vi = int'(yi[k]);
      checks++;
      if (k % 2 == 0) begin
        if (vr !== exr[k] || vi !== exi[k]) begin
          failures++;
          $display("FAIL mixed_exact X%0d: got re=%0d im=%0d, expected re=%0d im=%0d", k, vr, vi, exr[k], exi[k]);
        end
      end else if (vr < exr[k] - 1 || vr > exr[k] + 1 || vi < exi[k] - 1 || vi > exi[k] + 1) begin
        failures++;
        $display("FAIL mixed_twiddle X%0d: got re=%0d im=%0d, expected re=%0d im=%0d +-1", k, vr, vi, exr[k], exi[k]);
      end
    end
    tick(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== 0 || int'(yi[k]) !== 0) begin
        failures++;
        $display("FAIL mixed_flush X%0d: got re=%0d im=%0d, expected 0", k, yr[k], yi[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill(0, 0);
    xr[0] = 8'sd32;
    tick(1);
    fill(32, 0);
    tick(1);
    for (int n = 0; n < 8; n++) xr[n] = 8'(mix_re[n]);
    tick(1);
    fill(0, 0);
    checks++;
    if (int'(yr[0]) !== 32 || int'(yr[4]) !== 32) begin
      failures++;
      $display("FAIL b2b_impulse: got X0=%0d X4=%0d, expected 32 32", yr[0], yr[4]);
    end
    tick(1);
    checks++;
    if (int'(yr[0]) !== 256 || int'(yr[4]) !== 0) begin
      failures++;
      $display("FAIL b2b_dc: got X0=%0d X4=%0d, expected 256 0", yr[0], yr[4]);
    end
    tick(1);
    checks++;
    if (int'(yr[0]) !== 52 || int'(yr[4]) !== -12 || int'(yr[2]) !== 4) begin
      failures++;
      $display("FAIL b2b_mixed: got X0=%0d X2=%0d X4=%0d, expected 52 4 -12", yr[0], yr[2], yr[4]);
    end
  endtask

  task automatic test_enable_hold();
    fill(0, 0);
    tick(3);
    fill(32, 0);
    tick(1);
    fill(0, 0);
    xr[0] = 8'sd32;
    tick(1);
    fill(0, 0);
    tick(1);
    en = 1'b0;
    for (int n = 0; n < 8; n++) xr[n] = 8'(mix_re[n]);
    tick(5);
    expect_only0(256, 0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== er[k] || int'(yi[k]) !== ei[k]) begin
        failures++;
        $display("FAIL hold_frozen X%0d: got re=%0d im=%0d, expected re=%0d im=%0d", k, yr[k], yi[k], er[k], ei[k]);
      end
    end
    fill(0, 0);
    en = 1'b1;
    tick(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== 32 || int'(yi[k]) !== 0) begin
        failures++;
        $display("FAIL hold_resume X%0d: got re=%0d im=%0d, expected re=32 im=0", k, yr[k], yi[k]);
      end
    end
    tick(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== 0 || int'(yi[k]) !== 0) begin
        failures++;
        $display("FAIL hold_nogarbage X%0d: got re=%0d im=%0d, expected 0", k, yr[k], yi[k]);
      end
    end
  endtask

  task automatic test_extremes();
    fill(-128, -128);
    tick(3);
    expect_only0(-1024, -1024);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== er[k] || int'(yi[k]) !== ei[k]) begin
        failures++;
        $display("FAIL extreme_min X%0d: got re=%0d im=%0d, expected re=%0d im=%0d", k, yr[k], yi[k], er[k], ei[k]);
      end
    end
    for (int n = 0; n < 8; n++) begin
      xr[n] = (n % 2 == 0) ? 8'sd127 : -8'sd128;
      xi[n] = 8'sd0;
    end
    tick(3);
    expect_only0(-4, 0);
    er[4] = 1020;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (int'(yr[k]) !== er[k] || int'(yi[k]) !== ei[k]) begin
        failures++;
        $display("FAIL extreme_alt X%0d: got re=%0d im=%0d, expected re=%0d im=%0d", k, yr[k], yi[k], er[k], ei[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_mixed();
    test_back_to_back();
    test_enable_hold();
    test_extremes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
